iob_wishbone2iob: RTL and testbench

- Wishbone B4 classic slave to IOb-bus master bridge; the reverse direction of the IOb-to-Wishbone bridge used in front of the UART16550 core.
- Lets a Wishbone master (e.g. a third-party CPU or DMA) reach any IOb peripheral.
- One transaction in flight. Registered request path. Optional response timeout that terminates hung accesses with wb_err_o.

---
 rtl/iob_wishbone2iob.sv | 144 ++++++++++++++
 tb/tb_iob_wishbone2iob.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_wishbone2iob.sv
// Wishbone B4 classic slave to IOb-bus master bridge.
// One transaction in flight, registered IOb request, optional response timeout.
module iob_wishbone2iob #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [DATA_W/8-1:0]   wb_select_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] ACK    = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic              avalid_q, avalid_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [SEL_W-1:0]  wstrb_q,  wstrb_d;
  logic              ack_q,    ack_d;
  logic              err_q,    err_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              abort_q,  abort_d;
  logic              expire;
  logic              wbLive;

  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  // Master still wants the result: cycle held and never dropped since acceptance.
  assign wbLive = wb_cyc_i & ~abort_q;

  always_comb begin
    state_d  = state_q;
    avalid_d = avalid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_q) begin
          addr_d   = wb_addr_i;
          wdata_d  = wb_data_i;
          wstrb_d  = wb_we_i ? wb_select_i : '0;
          avalid_d = 1'b1;
          cnt_d    = '0;
          abort_d  = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (!wb_cyc_i) abort_d = 1'b1;
        // A zero strobe is a read on IOb, so it must wait for rvalid.
        if (iob_ready_i) begin
          avalid_d = 1'b0;
          state_d  = (wstrb_q != '0) ? ACK : RDWAIT;
        end else if (expire) begin
          avalid_d = 1'b0;
          err_d    = wbLive;
          state_d  = IDLE;
        end
      end
      RDWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!wb_cyc_i) abort_d = 1'b1;
        if (iob_rvalid_i) begin
          if (wbLive) rdata_d = iob_rdata_i;
          state_d = ACK;
        end else if (expire) begin
          err_d   = wbLive;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = wbLive;
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over the clock enable; a low enable freezes everything, stretching pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      avalid_q <= avalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_data_o    = rdata_q;
  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Self-checking bench for iob_wishbone2iob: scoreboarded IOb requests and read data,
// plus latency, timeout, abort, reset and clock-enable scenarios.
module tb_iob_wishbone2iob;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  logic          clk_i = 1'b0;
  logic          cke_i, rst_i;
  logic [AW-1:0] wb_addr_i;
  logic [SW-1:0] wb_select_i;
  logic          wb_we_i, wb_cyc_i, wb_stb_i;
  logic [DW-1:0] wb_data_i;
  logic          wb_ack_o, wb_err_o;
  logic [DW-1:0] wb_data_o;
  logic          iob_avalid_o;
  logic [AW-1:0] iob_addr_o;
  logic [DW-1:0] iob_wdata_o;
  logic [SW-1:0] iob_wstrb_o;
  logic          iob_ready_i, iob_rvalid_i;
  logic [DW-1:0] iob_rdata_i;

  req_t          expReq[$];
  req_t          obsReq[$];
  logic [DW-1:0] expResp[$];
  logic [DW-1:0] expData;
  int            total = 0;
  int            bad = 0;

  int   avalidCycles, ackCycle, errCycle, ackEdges, errEdges, ackHigh, unstable, both;
  logic rstZero;
  logic [DW-1:0] ackData;

  iob_wishbone2iob #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
    .wb_addr_i(wb_addr_i), .wb_select_i(wb_select_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_data_i(wb_data_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_data_o(wb_data_o),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
    cke_i = 1'b1; rst_i = 1'b0;
  endtask

  // Drives one Wishbone request (cycle 0) and an IOb slave; cycle c inputs are set after
  // sampling the outputs of cycle c. Observed requests go to obsReq.
  task automatic drive_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] sel, input int readyAt, input int rvalidAt,
                           input logic [DW-1:0] rdata, input int dropAt, input int ckeFrom,
                           input int ckeLen, input int rstAt, input int maxCycles, input bit dropOnAck);
    req_t cur;
    logic prevAck, prevErr, prevAvalid;
    logic cycOn;
    avalidCycles = 0; ackCycle = -1; errCycle = -1; ackEdges = 0; errEdges = 0;
    ackHigh = 0; unstable = 0; both = 0; rstZero = 1'b0; ackData = '0;
    cur = '0;
    cycOn = 1'b1;
    wb_addr_i = addr; wb_data_i = wdata; wb_select_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    iob_ready_i = (readyAt == 0); iob_rvalid_i = 1'b0; iob_rdata_i = ~rdata;
    prevAck = wb_ack_o; prevErr = wb_err_o; prevAvalid = iob_avalid_o;
    for (int c = 1; c <= maxCycles; c++) begin
      tick();
      if (iob_avalid_o) begin
        avalidCycles++;
        if (!prevAvalid) begin
          cur = '{iob_addr_o, iob_wdata_o, iob_wstrb_o};
          obsReq.push_back(cur);
        end else if (req_t'({iob_addr_o, iob_wdata_o, iob_wstrb_o}) != cur) begin
          unstable++;
        end
      end
      if (wb_ack_o) ackHigh++;
      if (wb_ack_o && !prevAck) begin
        ackEdges++;
        if (ackCycle < 0) begin ackCycle = c; ackData = wb_data_o; end
      end
      if (wb_err_o && !prevErr) begin
        errEdges++;
        if (errCycle < 0) errCycle = c;
      end
      if (wb_ack_o && wb_err_o) both++;
      if (c == rstAt + 1)
        rstZero = !(wb_ack_o | wb_err_o | iob_avalid_o) && wb_data_o == '0 &&
                  iob_addr_o == '0 && iob_wdata_o == '0 && iob_wstrb_o == '0;
      prevAck = wb_ack_o; prevErr = wb_err_o; prevAvalid = iob_avalid_o;
      if ((dropOnAck && (wb_ack_o || wb_err_o)) || (dropAt >= 0 && c >= dropAt)) cycOn = 1'b0;
      wb_cyc_i = cycOn; wb_stb_i = cycOn;
      iob_ready_i  = (readyAt >= 0 && c >= readyAt);
      iob_rvalid_i = (c == rvalidAt);
      iob_rdata_i  = (c == rvalidAt) ? rdata : ~rdata;
      cke_i = !(c >= ckeFrom && c < ckeFrom + ckeLen);
      rst_i = (c == rstAt);
    end
    quiet();
    repeat (4) tick();
  endtask

  task automatic test_reset;
    cke_i = 1'b0; rst_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_select_i = '1;
    wb_addr_i = 32'h1234; wb_data_i = 32'h5678;
    iob_ready_i = 1'b1; iob_rvalid_i = 1'b1; iob_rdata_i = 32'hFFFF_FFFF;
    repeat (3) tick();
    total++;
    if ({wb_ack_o, wb_err_o, iob_avalid_o} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {wb_ack_o, wb_err_o, iob_avalid_o});
    end
    total++;
    if ({iob_addr_o, iob_wdata_o, iob_wstrb_o, wb_data_o} !== '0) begin
      bad++; $display("[TB] FAIL reset_data got=%h/%h/%h/%h exp=0", iob_addr_o, iob_wdata_o, iob_wstrb_o, wb_data_o);
    end
    quiet();
    tick();
    expData = '0;
  endtask

  task automatic test_write;
    req_t e, o;
    e = '{32'h10, 32'hA5A5_0001, 4'b0011};
    expReq.push_back(e);
    drive_txn(1'b1, 32'h10, 32'hA5A5_0001, 4'b0011, 0, -1, '0, -1, -1, 0, -1, 8, 1'b1);
    e = expReq.pop_front();
    total++;
    if (obsReq.size() == 0) begin bad++; $display("[TB] FAIL write_req got=none exp=%h", e); end
    else begin
      o = obsReq.pop_front();
      if (o !== e) begin bad++; $display("[TB] FAIL write_req got=%h exp=%h", o, e); end
    end
    total++;
    if (avalidCycles !== 1) begin bad++; $display("[TB] FAIL write_avalid_len got=%0d exp=1", avalidCycles); end
    total++;
    if (ackCycle !== 3 || ackEdges !== 1) begin
      bad++; $display("[TB] FAIL write_ack got=cyc%0d/n%0d exp=cyc3/n1", ackCycle, ackEdges);
    end
    total++;
    if (errEdges !== 0 || both !== 0) begin bad++; $display("[TB] FAIL write_err got=%0d exp=0", errEdges); end
  endtask

  task automatic test_read_wait;
    req_t e, o;
    logic [DW-1:0] r;
    e = '{32'h24, 32'h0000_1234, 4'b0000};
    expReq.push_back(e);
    expResp.push_back(32'hDEAD_BEEF);
    drive_txn(1'b0, 32'h24, 32'h0000_1234, 4'hF, 4, 6, 32'hDEAD_BEEF, -1, -1, 0, -1, 12, 1'b1);
    e = expReq.pop_front();
    total++;
    if (obsReq.size() == 0) begin bad++; $display("[TB] FAIL read_req got=none exp=%h", e); end
    else begin
      o = obsReq.pop_front();
      if (o !== e) begin bad++; $display("[TB] FAIL read_req got=%h exp=%h", o, e); end
    end
    total++;
    if (avalidCycles !== 4 || unstable !== 0) begin
      bad++; $display("[TB] FAIL read_avalid got=len%0d/unstable%0d exp=len4/unstable0", avalidCycles, unstable);
    end
    total++;
    if (ackCycle !== 8 || ackEdges !== 1 || errEdges !== 0) begin
      bad++; $display("[TB] FAIL read_ack got=cyc%0d/n%0d/err%0d exp=cyc8/n1/err0", ackCycle, ackEdges, errEdges);
    end
    r = expResp.pop_front();
    expData = r;
    total++;
    if (ackData !== r) begin bad++; $display("[TB] FAIL read_data got=%h exp=%h", ackData, r); end
  endtask

  task automatic test_timeout;
    req_t e, o;
    e = '{32'h40, 32'h0BAD_0001, 4'b1111};
    expReq.push_back(e);
    drive_txn(1'b1, 32'h40, 32'h0BAD_0001, 4'hF, -1, -1, '0, -1, -1, 0, -1, 12, 1'b1);
    e = expReq.pop_front();
    total++;
    if (obsReq.size() == 0) begin bad++; $display("[TB] FAIL tmo_req got=none exp=%h", e); end
    else begin
      o = obsReq.pop_front();
      if (o !== e) begin bad++; $display("[TB] FAIL tmo_req got=%h exp=%h", o, e); end
    end
    total++;
    if (avalidCycles !== 8 || errCycle !== 9 || errEdges !== 1) begin
      bad++; $display("[TB] FAIL tmo_err got=len%0d/cyc%0d/n%0d exp=len8/cyc9/n1", avalidCycles, errCycle, errEdges);
    end
    total++;
    if (ackEdges !== 0) begin bad++; $display("[TB] FAIL tmo_noack got=%0d exp=0", ackEdges); end
    // A stray late rvalid must not produce anything.
    iob_rvalid_i = 1'b1; iob_rdata_i = 32'h1111_2222;
    tick();
    iob_rvalid_i = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if (wb_ack_o !== 1'b0 || wb_data_o !== expData) begin
        bad++; $display("[TB] FAIL tmo_late_rvalid got=ack%b/%h exp=ack0/%h", wb_ack_o, wb_data_o, expData);
      end
    end
    drive_txn(1'b1, 32'h44, 32'h0000_0042, 4'b0001, 0, -1, '0, -1, -1, 0, -1, 8, 1'b1);
    void'(obsReq.pop_front());
    total++;
    if (ackCycle !== 3 || errEdges !== 0) begin
      bad++; $display("[TB] FAIL tmo_next_write got=cyc%0d/err%0d exp=cyc3/err0", ackCycle, errEdges);
    end
  endtask

  task automatic test_abort;
    drive_txn(1'b0, 32'h80, '0, 4'hF, 2, 3, 32'h5555_AAAA, 1, -1, 0, -1, 10, 1'b1);
    void'(obsReq.pop_front());
    total++;
    if (avalidCycles !== 2) begin bad++; $display("[TB] FAIL abort_iob got=len%0d exp=len2", avalidCycles); end
    total++;
    if (ackEdges !== 0 || errEdges !== 0) begin
      bad++; $display("[TB] FAIL abort_resp got=ack%0d/err%0d exp=0/0", ackEdges, errEdges);
    end
    total++;
    if (wb_data_o !== expData) begin bad++; $display("[TB] FAIL abort_data got=%h exp=%h", wb_data_o, expData); end
    drive_txn(1'b1, 32'h84, 32'h77, 4'hF, 0, -1, '0, -1, -1, 0, -1, 8, 1'b1);
    void'(obsReq.pop_front());
    total++;
    if (ackCycle !== 3) begin bad++; $display("[TB] FAIL abort_next got=cyc%0d exp=cyc3", ackCycle); end
  endtask

  task automatic test_reset_mid_read;
    logic [DW-1:0] r;
    drive_txn(1'b0, 32'hC0, '0, 4'hF, 1, 4, 32'h9999_8888, 2, -1, 0, 2, 8, 1'b1);
    void'(obsReq.pop_front());
    expData = '0;
    total++;
    if (rstZero !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_zero got=%b exp=1", rstZero); end
    total++;
    if (ackEdges !== 0 || errEdges !== 0 || wb_data_o !== expData) begin
      bad++; $display("[TB] FAIL rst_mid_late got=ack%0d/err%0d/%h exp=0/0/%h", ackEdges, errEdges, wb_data_o, expData);
    end
    expResp.push_back(32'hCAFE_F00D);
    drive_txn(1'b0, 32'hC4, '0, 4'hF, 1, 2, 32'hCAFE_F00D, -1, -1, 0, -1, 8, 1'b1);
    void'(obsReq.pop_front());
    r = expResp.pop_front();
    expData = r;
    total++;
    if (ackCycle !== 4 || ackData !== r) begin
      bad++; $display("[TB] FAIL rst_next_read got=cyc%0d/%h exp=cyc4/%h", ackCycle, ackData, r);
    end
  endtask

  task automatic test_cke;
    drive_txn(1'b1, 32'h100, 32'h1, 4'hF, 1, -1, '0, -1, 1, 3, -1, 10, 1'b1);
    void'(obsReq.pop_front());
    total++;
    if (avalidCycles !== 4 || ackCycle !== 6 || ackEdges !== 1) begin
      bad++; $display("[TB] FAIL cke_req got=len%0d/cyc%0d/n%0d exp=len4/cyc6/n1", avalidCycles, ackCycle, ackEdges);
    end
    drive_txn(1'b1, 32'h104, 32'h2, 4'hF, 0, -1, '0, -1, 2, 3, -1, 10, 1'b1);
    void'(obsReq.pop_front());
    total++;
    if (ackCycle !== 6 || ackEdges !== 1 || ackHigh !== 1) begin
      bad++; $display("[TB] FAIL cke_ack got=cyc%0d/n%0d/hi%0d exp=cyc6/n1/hi1", ackCycle, ackEdges, ackHigh);
    end
    drive_txn(1'b1, 32'h108, 32'h3, 4'hF, 0, -1, '0, -1, 3, 3, -1, 10, 1'b1);
    void'(obsReq.pop_front());
    total++;
    if (ackCycle !== 3 || ackEdges !== 1 || ackHigh !== 4) begin
      bad++; $display("[TB] FAIL cke_stretch got=cyc%0d/n%0d/hi%0d exp=cyc3/n1/hi4", ackCycle, ackEdges, ackHigh);
    end
  endtask

  task automatic test_back_to_back;
    req_t e, o;
    e = '{32'h200, 32'hB2B0_0000, 4'b1100};
    expReq.push_back(e);
    expReq.push_back(e);
    drive_txn(1'b1, 32'h200, 32'hB2B0_0000, 4'b1100, 0, -1, '0, -1, -1, 0, -1, 6, 1'b0);
    total++;
    if (ackEdges !== 1 || ackCycle !== 3 || avalidCycles !== 2) begin
      bad++; $display("[TB] FAIL b2b_timing got=n%0d/cyc%0d/len%0d exp=n1/cyc3/len2", ackEdges, ackCycle, avalidCycles);
    end
    for (int i = 0; i < 2; i++) begin
      e = expReq.pop_front();
      total++;
      if (obsReq.size() == 0) begin bad++; $display("[TB] FAIL b2b_req%0d got=none exp=%h", i, e); end
      else begin
        o = obsReq.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL b2b_req%0d got=%h exp=%h", i, o, e); end
      end
    end
  endtask

  initial begin
    quiet();
    wb_addr_i = '0; wb_data_i = '0; wb_select_i = '0;
    expData = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_abort();
    test_reset_mid_read();
    test_cke();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
